// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Purpose  : Decode stage feeding the ALU; owns the 16x32 register file with
//            write-back bypass and a one-cycle load-use interlock after LDR.
// Revision : 1.0
// ============================================================================
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        wb_en,
    input  logic [3:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] In1,
    output logic [31:0] In2,
    output logic [3:0]  Opcode,
    output logic [3:0]  Cond,
    output logic        S,
    output logic [2:0]  SR_Cont,
    output logic [4:0]  SR_Bit,
    output logic [15:0] Immediate,
    output logic [3:0]  Rd,
    output logic        ill
);

    localparam logic [3:0] c_OP_MOVI = 4'b0110;
    localparam logic [3:0] c_OP_LDR  = 4'b1101;
    localparam logic [3:0] c_OP_STR  = 4'b1110;

    logic [31:0] r_regs [16];
    logic        r_ld_pend;
    logic [3:0]  r_ld_rd;

    logic        r_out_valid;
    logic [31:0] r_in1;
    logic [31:0] r_in2;
    logic [3:0]  r_opcode;
    logic [3:0]  r_cond;
    logic        r_s;
    logic [2:0]  r_sr_cont;
    logic [4:0]  r_sr_bit;
    logic [15:0] r_imm;
    logic [3:0]  r_rd;
    logic        r_ill;

    logic [3:0]  w_opcode;
    logic [3:0]  w_rn;
    logic [3:0]  w_rm;
    logic        w_ill;
    logic        w_stall;
    logic        w_accept;
    logic        w_handoff;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic        w_unused_bits;

    assign w_opcode      = instr[27:24];
    assign w_rn          = instr[15:12];
    assign w_rm          = instr[11:8];
    assign w_unused_bits = ^instr[2:0];

    always_comb begin
        w_ill = 1'b1;
        if (w_opcode[3] == 1'b0 || w_opcode == c_OP_LDR || w_opcode == c_OP_STR)
            w_ill = 1'b0;
    end

    // MOV imm carries no register sources, so it never waits on a load.
    assign w_stall   = r_ld_pend && (w_opcode != c_OP_MOVI) &&
                       ((w_rn == r_ld_rd) || (w_rm == r_ld_rd));
    assign in_ready  = !flush && !w_stall && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_handoff = r_out_valid && out_ready;

    assign w_op_a = (wb_en && wb_addr == w_rn) ? wb_data : r_regs[w_rn];
    assign w_op_b = (wb_en && wb_addr == w_rm) ? wb_data : r_regs[w_rm];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++)
                r_regs[i] <= 32'd0;
        end else if (wb_en) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // The bubble lasts exactly one cycle, so the pending flag is rebuilt every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_pend <= 1'b0;
            r_ld_rd   <= 4'd0;
        end else begin
            r_ld_pend <= !flush && w_handoff && (r_opcode == c_OP_LDR);
            if (!flush && w_handoff && r_opcode == c_OP_LDR)
                r_ld_rd <= r_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_in1       <= 32'd0;
            r_in2       <= 32'd0;
            r_opcode    <= 4'd0;
            r_cond      <= 4'd0;
            r_s         <= 1'b0;
            r_sr_cont   <= 3'd0;
            r_sr_bit    <= 5'd0;
            r_imm       <= 16'd0;
            r_rd        <= 4'd0;
            r_ill       <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_in1       <= w_op_a;
            r_in2       <= w_op_b;
            r_opcode    <= w_opcode;
            r_cond      <= instr[31:28];
            r_s         <= instr[23] && !w_ill;
            r_sr_cont   <= instr[22:20];
            r_sr_bit    <= instr[7:3];
            r_imm       <= (w_opcode == c_OP_MOVI) ? instr[15:0] : 16'd0;
            r_rd        <= instr[19:16];
            r_ill       <= w_ill;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign In1       = r_in1;
    assign In2       = r_in2;
    assign Opcode    = r_opcode;
    assign Cond      = r_cond;
    assign S         = r_s;
    assign SR_Cont   = r_sr_cont;
    assign SR_Bit    = r_sr_bit;
    assign Immediate = r_imm;
    assign Rd        = r_rd;
    assign ill       = r_ill;

endmodule
`default_nettype wire
